// File: rtl/seg_capture_if.sv
// seg_capture_if -- display-bus read-back interface for seg_capture.
//
// Signals:
//   seg_in     [6:0]  segment bus {g,f,e,d,c,b,a} (polarity chosen at build time)
//   dig_en     [1:0]  active-high digit enables, bit0 = units, bit1 = tens
//   clr_err           synchronous clear of err_sticky
//   unidades   [3:0]  committed units value (0..9, 4'hF = blank)
//   decenas    [3:0]  committed tens value (0..9, 4'hF = blank)
//   upd               one-cycle pulse when a committed value changes
//   err               one-cycle pulse when an invalid pattern is committed
//   err_sticky        latched err, cleared by reset or clr_err
//
// Modports: master drives the bus and reads results; slave is the capture block.
interface seg_capture_if;
  logic [6:0] seg_in;
  logic [1:0] dig_en;
  logic       clr_err;
  logic [3:0] unidades;
  logic [3:0] decenas;
  logic       upd;
  logic       err;
  logic       err_sticky;

  modport master (
    output seg_in,
    output dig_en,
    output clr_err,
    input  unidades,
    input  decenas,
    input  upd,
    input  err,
    input  err_sticky
  );

  modport slave (
    input  seg_in,
    input  dig_en,
    input  clr_err,
    output unidades,
    output decenas,
    output upd,
    output err,
    output err_sticky
  );
endinterface

// File: rtl/seg_capture.sv
// seg_capture -- seven-segment bus reader.
//
// Samples a time-multiplexed two-digit segment bus, converts each digit's pattern back
// to BCD and commits it once STABLE_CYC identical samples of that digit have been seen.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     seg_capture_if.slave (seg_in, dig_en, clr_err in; unidades, decenas,
//           upd, err, err_sticky out)
//
// Parameter:
//   STABLE_CYC  consecutive identical samples needed to commit a digit (2..255)
//
// Build option:
//   SEG_CAPTURE_ACTIVE_HIGH_EN  when defined, seg_in is an active-high bus and is
//                               inverted before sampling; otherwise active-low.
module seg_capture #(
  parameter int unsigned STABLE_CYC = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  seg_capture_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [6:0] SegBlank = 7'h7F;

  // Returns {valid, value}; blank is a valid pattern decoding to 4'hF.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h40:   res = 5'h10;
      7'h79:   res = 5'h11;
      7'h24:   res = 5'h12;
      7'h30:   res = 5'h13;
      7'h19:   res = 5'h14;
      7'h12:   res = 5'h15;
      7'h02:   res = 5'h16;
      7'h78:   res = 5'h17;
      7'h00:   res = 5'h18;
      7'h10:   res = 5'h19;
      7'h7F:   res = 5'h1F;
      default: res = 5'h0F;
    endcase
    return res;
  endfunction

  // Internal representation is always active-low.
  logic [6:0] w_seg_pin;
`ifdef SEG_CAPTURE_ACTIVE_HIGH_EN
  assign w_seg_pin = ~bus.seg_in;
`else
  assign w_seg_pin = bus.seg_in;
`endif

  logic [6:0]            r_seg;
  logic [1:0]            r_en;
  logic [1:0][6:0]       r_cand;
  logic [1:0][CntW-1:0]  r_cnt;
  logic [3:0]            r_unid;
  logic [3:0]            r_dec;
  logic                  r_upd;
  logic                  r_err;
  logic                  r_err_sticky;

  logic [1:0][6:0]       w_cand_d;
  logic [1:0][CntW-1:0]  w_cnt_d;
  logic [3:0]            w_unid_d;
  logic [3:0]            w_dec_d;
  logic                  w_upd_d;
  logic                  w_err_d;
  logic                  w_err_sticky_d;
  logic                  w_dig;
  logic [4:0]            w_dec_res;

  assign w_dec_res = decode_seg(r_seg);

  always_comb begin
    w_cand_d       = r_cand;
    w_cnt_d        = r_cnt;
    w_unid_d       = r_unid;
    w_dec_d        = r_dec;
    w_upd_d        = 1'b0;
    w_err_d        = 1'b0;
    w_dig          = r_en[1];

    if (r_en == 2'b11) begin
      // Overlapping enables: treat as a glitch, restart both streaks.
      w_cnt_d = '0;
    end else if (r_en != 2'b00) begin
      if (r_seg == r_cand[w_dig]) begin
        if (r_cnt[w_dig] != CntMax) begin
          w_cnt_d[w_dig] = r_cnt[w_dig] + CntOne;
        end
        // Commit only on the transition into saturation.
        if (r_cnt[w_dig] == CntMax - CntOne) begin
          if (w_dec_res[4]) begin
            if (!w_dig) begin
              w_unid_d = w_dec_res[3:0];
              w_upd_d  = (r_unid != w_dec_res[3:0]);
            end else begin
              w_dec_d  = w_dec_res[3:0];
              w_upd_d  = (r_dec != w_dec_res[3:0]);
            end
          end else begin
            w_err_d = 1'b1;
          end
        end
      end else begin
        w_cand_d[w_dig] = r_seg;
        w_cnt_d[w_dig]  = CntOne;
      end
    end

    // A new error wins over a simultaneous clear.
    w_err_sticky_d = w_err_d | (r_err_sticky & ~bus.clr_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg        <= SegBlank;
      r_en         <= 2'b00;
      r_cand       <= {SegBlank, SegBlank};
      r_cnt        <= '0;
      r_unid       <= 4'hF;
      r_dec        <= 4'hF;
      r_upd        <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_seg        <= w_seg_pin;
      r_en         <= bus.dig_en;
      r_cand       <= w_cand_d;
      r_cnt        <= w_cnt_d;
      r_unid       <= w_unid_d;
      r_dec        <= w_dec_d;
      r_upd        <= w_upd_d;
      r_err        <= w_err_d;
      r_err_sticky <= w_err_sticky_d;
    end
  end

  assign bus.unidades   = r_unid;
  assign bus.decenas    = r_dec;
  assign bus.upd        = r_upd;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture -- directed self-checking bench for seg_capture (STABLE_CYC = 4,
// active-low build). Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_seg_capture;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_upd;
  int   n_err;
  int   upd_base;
  int   err_base;

  seg_capture_if bus_if ();

  seg_capture #(
    .STABLE_CYC (4)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; accumulate pulse counts seen after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_upd += int'(bus_if.upd);
      n_err += int'(bus_if.err);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [6:0] seg, input logic [1:0] en, input int n);
    bus_if.seg_in = seg;
    bus_if.dig_en = en;
    step(n);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_upd   = 0;
    n_err   = 0;
    rst             = 1'b1;
    bus_if.seg_in   = 7'h7F;
    bus_if.dig_en   = 2'b00;
    bus_if.clr_err  = 1'b0;
    step(2);
    rst = 1'b0;

    // Reset state
    chk("rst_unid", 8'(bus_if.unidades), 8'hF);
    chk("rst_dec", 8'(bus_if.decenas), 8'hF);
    chk("rst_upd", 8'(bus_if.upd), 8'h0);
    chk("rst_err", 8'(bus_if.err), 8'h0);
    chk("rst_sticky", 8'(bus_if.err_sticky), 8'h0);

    // Units = 3: sample loaded at edge 0, commit at edge 4
    n_upd = 0;
    drive(7'h30, 2'b01, 4);
    chk("t1_unid_early", 8'(bus_if.unidades), 8'hF);
    step(1);
    chk("t1_unid", 8'(bus_if.unidades), 8'h3);
    chk("t1_upd", 8'(bus_if.upd), 8'h1);
    chk("t1_dec", 8'(bus_if.decenas), 8'hF);
    step(1);
    chk("t1_upd_fall", 8'(bus_if.upd), 8'h0);
    step(3);
    chk("t1_upd_once", 8'(n_upd), 8'd1);

    // Interleaved units 5 / tens 1
    upd_base = n_upd;
    err_base = n_err;
    for (int i = 0; i < 8; i++) begin
      drive(7'h12, 2'b01, 1);
      drive(7'h79, 2'b10, 1);
    end
    drive(7'h7F, 2'b00, 2);
    chk("t2_unid", 8'(bus_if.unidades), 8'h5);
    chk("t2_dec", 8'(bus_if.decenas), 8'h1);
    chk("t2_upd_cnt", 8'(n_upd - upd_base), 8'd2);
    chk("t2_err_cnt", 8'(n_err - err_base), 8'd0);

    // Broken 6 streak, then 8
    upd_base = n_upd;
    drive(7'h02, 2'b01, 3);
    drive(7'h00, 2'b01, 4);
    drive(7'h7F, 2'b00, 2);
    chk("t3_unid", 8'(bus_if.unidades), 8'h8);
    chk("t3_upd_cnt", 8'(n_upd - upd_base), 8'd1);

    // Invalid tens pattern
    upd_base = n_upd;
    err_base = n_err;
    drive(7'h7E, 2'b10, 8);
    drive(7'h7F, 2'b00, 2);
    chk("t4_err_cnt", 8'(n_err - err_base), 8'd1);
    chk("t4_sticky", 8'(bus_if.err_sticky), 8'h1);
    chk("t4_dec", 8'(bus_if.decenas), 8'h1);
    chk("t4_upd_cnt", 8'(n_upd - upd_base), 8'd0);
    bus_if.clr_err = 1'b1;
    step(1);
    bus_if.clr_err = 1'b0;
    chk("t4_clr", 8'(bus_if.err_sticky), 8'h0);

    // Overlap at cnt = 3 restarts the streak
    upd_base = n_upd;
    err_base = n_err;
    drive(7'h19, 2'b01, 3);
    drive(7'h19, 2'b11, 1);
    drive(7'h19, 2'b01, 3);
    drive(7'h7F, 2'b00, 2);
    chk("t5_no_commit", 8'(bus_if.unidades), 8'h8);
    chk("t5_err_cnt", 8'(n_err - err_base), 8'd0);
    drive(7'h19, 2'b01, 1);
    drive(7'h7F, 2'b00, 2);
    chk("t5_unid", 8'(bus_if.unidades), 8'h4);
    chk("t5_upd_cnt", 8'(n_upd - upd_base), 8'd1);

    // Commit 9, then reset
    drive(7'h10, 2'b01, 4);
    drive(7'h7F, 2'b00, 1);
    chk("t6_unid", 8'(bus_if.unidades), 8'h9);
    chk("t6_upd", 8'(bus_if.upd), 8'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_rst_unid", 8'(bus_if.unidades), 8'hF);
    chk("t6_rst_dec", 8'(bus_if.decenas), 8'hF);
    chk("t6_rst_upd", 8'(bus_if.upd), 8'h0);

    // Streak restarts from scratch after reset
    drive(7'h10, 2'b01, 4);
    chk("t6_restart_early", 8'(bus_if.unidades), 8'hF);
    step(1);
    chk("t6_restart", 8'(bus_if.unidades), 8'h9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
